// File: rtl/uart_rx_ctrl_if.sv
// Receive-word hand-off between uart_rx_ctrl (master) and the APB RX data register (slave).
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        output parity_err,
        output busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        input  parity_err,
        input  busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive front end: synchronizer, oversampled start qualification, mid-bit sampling
// and valid/ack word hand-off. Define UART_RX_PARITY_EN to insert a parity bit check.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           baud_tick,
    input  logic           rx_in,
    input  logic           parity_odd,
    uart_rx_ctrl_if.master rx_bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    state_t                 state_reg;
    state_t                 state_next;
    logic                   sync_meta_reg;
    logic                   rx_s_reg;
    logic [TW-1:0]          tick_cnt_reg;
    logic [BW-1:0]          bit_cnt_reg;
    logic [DATA_BITS-1:0]   shreg_reg;
    logic                   armed_reg;
    logic [DATA_BITS-1:0]   rx_data_reg;
    logic                   rx_valid_reg;
    logic                   frame_err_reg;
    logic                   overrun_err_reg;
    logic                   parity_err_reg;
    logic                   parity_bad;

    logic                   busy;
    logic                   data_sample;
    logic                   stop_sample;
    logic                   stop_good;
    logic                   load_word;
    logic                   flag_frame;
    logic                   flag_overrun;
    logic                   flag_parity;

    // Both stages reset to the idle (high) line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 1'b1;
            rx_s_reg      <= 1'b1;
        end else begin
            sync_meta_reg <= rx_in;
            rx_s_reg      <= sync_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (baud_tick) begin
            case (state_reg)
                S_IDLE:   if (armed_reg && !rx_s_reg) state_next = S_START;
                S_START:  if (tick_cnt_reg == TICK_MID) state_next = rx_s_reg ? S_IDLE : S_DATA;
                S_DATA:   if (tick_cnt_reg == TICK_LAST && bit_cnt_reg == BIT_LAST) state_next = AFTER_DATA;
                S_PARITY: if (tick_cnt_reg == TICK_LAST) state_next = S_STOP;
                S_STOP:   if (tick_cnt_reg == TICK_LAST) state_next = S_IDLE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // A good stop bit while the previous word is being acked in the same cycle still loads.
    always_comb begin
        busy         = (state_reg != S_IDLE);
        data_sample  = baud_tick && (state_reg == S_DATA) && (tick_cnt_reg == TICK_LAST);
        stop_sample  = baud_tick && (state_reg == S_STOP) && (tick_cnt_reg == TICK_LAST);
        flag_frame   = stop_sample && !rx_s_reg;
        flag_parity  = stop_sample && rx_s_reg && parity_bad;
        stop_good    = stop_sample && rx_s_reg && !parity_bad;
        load_word    = stop_good && (!rx_valid_reg || rx_bus.rx_ack);
        flag_overrun = stop_good && rx_valid_reg && !rx_bus.rx_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shreg_reg    <= '0;
            armed_reg    <= 1'b0;
        end else if (baud_tick) begin
            if (state_next != state_reg || tick_cnt_reg == TICK_LAST) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
            // Only a high line seen while idle re-arms, so a held break cannot retrigger.
            armed_reg <= (state_reg == S_IDLE) && (state_next == S_IDLE) && (armed_reg || rx_s_reg);
            if (data_sample) begin
                shreg_reg   <= {rx_s_reg, shreg_reg[DATA_BITS-1:1]};
                bit_cnt_reg <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bad_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bad_reg <= 1'b0;
        end else if (baud_tick && state_reg == S_PARITY && tick_cnt_reg == TICK_LAST) begin
            parity_bad_reg <= (rx_s_reg != (^shreg_reg ^ parity_odd));
        end
    end

    assign parity_bad = parity_bad_reg;
`else
    logic unused_parity_odd;

    assign unused_parity_odd = parity_odd;
    assign parity_bad        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
            parity_err_reg  <= 1'b0;
        end else begin
            frame_err_reg   <= flag_frame;
            overrun_err_reg <= flag_overrun;
            parity_err_reg  <= flag_parity;
            if (load_word) begin
                rx_data_reg  <= shreg_reg;
                rx_valid_reg <= 1'b1;
            end else if (rx_bus.rx_ack) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data     = rx_data_reg;
    assign rx_bus.rx_valid    = rx_valid_reg;
    assign rx_bus.frame_err   = frame_err_reg;
    assign rx_bus.overrun_err = overrun_err_reg;
    assign rx_bus.parity_err  = parity_err_reg;
    assign rx_bus.busy        = busy;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus random traffic, checked every cycle against
// a tick-offset model of the receiver. Honours UART_RX_PARITY_EN like the design.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic baud_tick   = 1'b0;
    logic rx_in       = 1'b1;
    logic parity_odd  = 1'b0;
    logic ack_req     = 1'b0;
    logic rand_ack_en = 1'b0;

    uart_rx_ctrl_if #(.DATA_BITS(DB)) bus ();

    uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .rx_in      (rx_in),
        .parity_odd (parity_odd),
        .rx_bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int oe_cnt = 0;
    int pe_cnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Tick and ack driver, offset from the negedge so it never races the stimulus thread.
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(negedge clk);
            #2;
            phase     = (phase + 1) % TICK_DIV;
            baud_tick = (phase == 0);
            bus.rx_ack = ack_req || (rand_ack_en && ($urandom_range(0, 99) < 4));
        end
    end

    // Reference model: a frame is timed purely by tick offsets from the tick that saw
    // the falling edge: start check at OS/2, bit k at OS/2 + k*OS.
    logic          m_s1, m_s2, m_armed, m_active, m_pbad;
    int            m_age;
    logic [DB-1:0] m_bits;
    logic [DB-1:0] exp_data;
    logic          exp_valid, exp_fe, exp_oe, exp_pe;

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_armed = 1'b0; m_active = 1'b0; m_pbad = 1'b0;
        m_age = 0; m_bits = '0;
        exp_data = '0; exp_valid = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0; exp_pe = 1'b0;
    endtask

    task automatic model_step();
        logic v;
        bit   loaded;
        int   k;
        v = m_s2; m_s2 = m_s1; m_s1 = rx_in;
        exp_fe = 1'b0; exp_oe = 1'b0; exp_pe = 1'b0; loaded = 1'b0;
        if (baud_tick) begin
            if (!m_active) begin
                if (m_armed && !v) begin
                    m_active = 1'b1; m_age = 0; m_armed = 1'b0; m_pbad = 1'b0;
                end else if (v) begin
                    m_armed = 1'b1;
                end
            end else begin
                m_age++;
                if (m_age == OS / 2) begin
                    if (v) m_active = 1'b0;
                end else if (m_age > OS / 2 && (m_age - OS / 2) % OS == 0) begin
                    k = (m_age - OS / 2) / OS;
                    if (k <= DB) begin
                        m_bits[k-1] = v;
                    end else if (PAR && k == DB + 1) begin
                        m_pbad = (v != (^m_bits ^ parity_odd));
                    end else begin
                        m_active = 1'b0;
                        if (!v) exp_fe = 1'b1;
                        else if (m_pbad) exp_pe = 1'b1;
                        else if (exp_valid && !bus.rx_ack) exp_oe = 1'b1;
                        else begin
                            exp_data = m_bits; exp_valid = 1'b1; loaded = 1'b1;
                        end
                    end
                end
            end
        end
        if (!loaded && bus.rx_ack) exp_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Single compare process: every output, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk1("rx_valid", bus.rx_valid, exp_valid);
            chkd("rx_data", bus.rx_data, exp_data);
            chk1("frame_err", bus.frame_err, exp_fe);
            chk1("overrun_err", bus.overrun_err, exp_oe);
            chk1("parity_err", bus.parity_err, exp_pe);
            chk1("busy", bus.busy, m_active);
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun_err) oe_cnt++;
            if (bus.parity_err) pe_cnt++;
        end
    end

    task automatic hold(input logic val, input int ncyc);
        rx_in = val;
        repeat (ncyc) @(negedge clk);
    endtask

    function automatic logic good_par(input logic [DB-1:0] d);
        return ^d ^ parity_odd;
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_bit);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < DB; i++) hold(d[i], BIT_CLKS);
        if (PAR) hold(par_bit, BIT_CLKS);
        hold(stop_bit, BIT_CLKS);
    endtask

    task automatic send_good(input logic [DB-1:0] d);
        send_frame(d, 1'b1, good_par(d));
    endtask

    task automatic do_ack();
        ack_req = 1'b1;
        @(negedge clk);
        ack_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [DB-1:0] rd;
    logic          rstop, rpar;
    int            c0;

    initial begin
        #3;
        chk1("rst_valid", bus.rx_valid, 1'b0);
        chkd("rst_data", bus.rx_data, '0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_ferr", bus.frame_err, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 2 * BIT_CLKS);

        // 0xA5 clean frame
        send_good(8'hA5);
        chk1("a5_valid", bus.rx_valid, 1'b1);
        chkd("a5_data", bus.rx_data, 8'hA5);
        chk1("a5_busy", bus.busy, 1'b0);
        chki("a5_no_err", fe_cnt + oe_cnt + pe_cnt, 0);
        do_ack();
        chk1("a5_acked", bus.rx_valid, 1'b0);

        // 5-tick glitch is rejected at the mid-start check
        hold(1'b0, 5 * TICK_DIV);
        hold(1'b1, 2 * BIT_CLKS);
        chk1("glitch_valid", bus.rx_valid, 1'b0);
        chk1("glitch_busy", bus.busy, 1'b0);
        chki("glitch_no_err", fe_cnt + oe_cnt + pe_cnt, 0);

        // bad stop bit, then a held break must not restart the receiver
        c0 = fe_cnt;
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        hold(1'b0, 3 * BIT_CLKS);
        chki("break_ferr", fe_cnt - c0, 1);
        chk1("break_valid", bus.rx_valid, 1'b0);
        chk1("break_busy", bus.busy, 1'b0);
        hold(1'b1, BIT_CLKS);
        send_good(8'h81);
        chkd("after_break_data", bus.rx_data, 8'h81);
        chk1("after_break_valid", bus.rx_valid, 1'b1);
        do_ack();

        // overrun: second word dropped, first kept
        c0 = oe_cnt;
        send_good(8'h11);
        hold(1'b1, BIT_CLKS);
        send_good(8'h22);
        hold(1'b1, BIT_CLKS / 2);
        chki("ovr_pulses", oe_cnt - c0, 1);
        chkd("ovr_data", bus.rx_data, 8'h11);
        chk1("ovr_valid", bus.rx_valid, 1'b1);
        do_ack();
        chk1("ovr_acked", bus.rx_valid, 1'b0);

        // asynchronous reset in data bit 4 of 0xFF
        hold(1'b0, BIT_CLKS);
        hold(1'b1, 4 * BIT_CLKS + BIT_CLKS / 2);
        chk1("pre_rst_busy", bus.busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chkd("mid_rst_data", bus.rx_data, '0);
        chk1("mid_rst_valid", bus.rx_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 2 * BIT_CLKS);
        send_good(8'h5A);
        chkd("post_rst_data", bus.rx_data, 8'h5A);
        chk1("post_rst_valid", bus.rx_valid, 1'b1);
        do_ack();

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1);
        chkd("par_ok_data", bus.rx_data, 8'h07);
        chk1("par_ok_valid", bus.rx_valid, 1'b1);
        do_ack();
        c0 = pe_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        chki("par_bad_pulse", pe_cnt - c0, 1);
        chk1("par_bad_valid", bus.rx_valid, 1'b0);
        hold(1'b1, BIT_CLKS);
`endif

        // random traffic with sporadic acks, bad stops, bad parity and glitches
        rand_ack_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rd         = DB'($urandom);
            rstop      = ($urandom_range(0, 9) != 0);
            parity_odd = 1'($urandom_range(0, 1));
            rpar       = good_par(rd) ^ ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) begin
                hold(1'b0, $urandom_range(4, 24));
                hold(1'b1, BIT_CLKS);
            end
            send_frame(rd, rstop, rpar);
            hold(1'b1, $urandom_range(BIT_CLKS / 2, 3 * BIT_CLKS));
        end
        rand_ack_en = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive front end. Oversamples the asynchronous serial line, detects and qualifies the start bit, and samples each data bit at mid-bit.
- Assembles each frame LSB-first into a parallel word, checks the stop bit, and presents the word to the APB register layer with a valid/ack handshake.
- Sits between the rx pin and the APB-side RX data register; consumes baud_tick from the baud generator.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=8).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- baud_tick  input  1  single-cycle enable pulse at OVERSAMPLE x baud rate
- rx_in  input  1  raw asynchronous serial line, idle high
- rx_ack  input  1  consumer has taken rx_data; clears rx_valid
- parity_odd  input  1  odd parity when 1, even when 0; used only with PARITY_EN
- rx_data  output  DATA_BITS  last good received word
- rx_valid  output  1  rx_data holds an unread word
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun_err  output  1  one-cycle pulse: frame completed while rx_valid=1
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without PARITY_EN)
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values:
  - All outputs 0; rx_data = 0.
  - FSM in IDLE; tick counter and bit counter 0; armed = 0.
  - Both synchronizer flops = 1.
- Synchronizer: rx_in passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s and happen only on cycles with baud_tick=1.
- Tick counter: counts baud_tick 0..OVERSAMPLE-1 and wraps. It is cleared on every state entry.
- IDLE:
  - armed is set when rx_s=1 at a tick.
  - When armed=1 and rx_s=0 at a tick: go to START, clear the tick counter, clear armed.
- START: at tick count OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=1: false start; return to IDLE, no error flag.
  - rx_s=0: clear the tick counter and go to DATA.
- DATA:
  - At each tick count OVERSAMPLE-1 (mid-bit), shift right: shreg <= {rx_s, shreg[DATA_BITS-1:1]}, and increment the bit counter.
  - After DATA_BITS samples, go to PARITY (PARITY_EN) or STOP.
- STOP: at tick count OVERSAMPLE-1, sample rx_s.
  - rx_s=1 and rx_valid=0: in the same cycle, rx_data <= shreg and rx_valid <= 1.
  - rx_s=1 and rx_valid=1: pulse overrun_err; rx_data is unchanged and the new word is dropped.
  - rx_s=0: pulse frame_err; word dropped.
  - In all cases, return to IDLE. armed=0, so a stuck-low line (break) cannot retrigger until it returns high.
- Latency: rx_valid rises 1 clk after the baud_tick at mid stop bit.
- Handshake:
  - rx_valid stays high until a cycle with rx_ack=1, then clears the next cycle.
  - rx_ack with rx_valid=0 is ignored.
  - Simultaneous rx_ack and a new word load in the same cycle: the load wins; rx_valid stays 1 with the new data and no overrun is flagged.
- Error pulses last exactly one clk, and the word is never loaded on any error.
- rx_ack, parity_odd and other inputs are ignored mid-frame except as stated above.
- Asynchronous reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA. At tick count OVERSAMPLE-1 it samples the parity bit and compares it with ^shreg ^ parity_odd (expected bit).
  - On mismatch, an error flag is held through STOP.
  - At STOP, if the stop bit is good but parity is bad: pulse parity_err and drop the word.
  - If both parity and stop bit fail, only frame_err is pulsed.
- Undefined: no PARITY state; parity_odd is unused; parity_err is tied 0.

Test Plan:
- Frame 0xA5 (LSB-first 1,0,1,0,0,1,0,1), stop=1, OVERSAMPLE=16, baud_tick every 4 clk -> rx_valid=1 with rx_data=0xA5; busy returns 0; no error pulses.
- Glitch low for 5 ticks on an idle line -> START rejects at tick 7; FSM returns to IDLE; rx_valid stays 0; no errors.
- Frame 0x3C with stop=0, line then held low 3 bit-times -> frame_err pulses once; rx_valid=0; no new START until the line goes high, after which 0x81 is received correctly.
- Two frames 0x11 then 0x22 with no rx_ack -> rx_valid=1, rx_data=0x11, overrun_err pulses once at the second stop bit; rx_ack then clears rx_valid.
- rst_n asserted during data bit 4 of 0xFF -> all outputs 0 at once; next frame 0x5A is received correctly.
- With UART_RX_PARITY_EN and parity_odd=0:
  - Frame 0x07 with parity bit 1 -> rx_data=0x07.
  - Same frame with parity bit 0 -> parity_err pulses; rx_valid stays 0.
